// File: rtl/uart_rx_oversampled.sv
// UART receiver: two-flop synchroniser, mid-bit 3-sample majority vote,
// optional parity, 1-2 stop bits and a one-entry valid/ready holding register.
module uart_rx_oversampled #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk50Mhz,
    input  logic                 reset,
    input  logic                 portRX,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int DIV    = CLK_HZ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int MID    = OVERSAMPLE / 2;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TICK_W-1:0] TICK_A    = TICK_W'(MID - 1);
    localparam logic [TICK_W-1:0] TICK_B    = TICK_W'(MID);
    localparam logic [TICK_W-1:0] TICK_C    = TICK_W'(MID + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS);
    localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic                 rx_meta;
    logic                 rx_s;
    logic [2:0]           state;
    logic [DIV_W-1:0]     div_cnt;
    logic [TICK_W-1:0]    tick_cnt;
    logic [3:0]           bit_cnt;
    logic                 tick;
    logic                 sample_a;
    logic                 sample_b;
    logic                 decide;
    logic                 bit_end;
    logic                 samp_a;
    logic                 samp_b;
    logic                 majority;
    logic                 par_expect;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 perr_pend;
    logic                 ferr_pend;
    logic                 armed;
    logic                 done;
    logic [DATA_BITS-1:0] frame_data;
    logic                 frame_perr;
    logic                 frame_ferr;

    always_ff @(posedge clk50Mhz or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= portRX;
            rx_s    <= rx_meta;
        end
    end

    assign tick     = (state != S_IDLE) && (div_cnt == DIV_LAST);
    assign sample_a = tick && (tick_cnt == TICK_A);
    assign sample_b = tick && (tick_cnt == TICK_B);
    assign decide   = tick && (tick_cnt == TICK_C);
    assign bit_end  = tick && (tick_cnt == TICK_LAST);

    // The third sample is the live rx_s, so the vote resolves on the decide tick itself.
    assign majority   = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    assign par_expect = (^shift_reg) ^ (PARITY == 2);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk50Mhz or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if ((state == S_IDLE) || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk50Mhz or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (state == S_IDLE) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= bit_end ? '0 : tick_cnt + TICK_W'(1);
        end
    end

    always_ff @(posedge clk50Mhz or posedge reset) begin
        if (reset) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            if (sample_a) samp_a <= rx_s;
            if (sample_b) samp_b <= rx_s;
        end
    end

    always_ff @(posedge clk50Mhz or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            perr_pend  <= 1'b0;
            ferr_pend  <= 1'b0;
            armed      <= 1'b0;
            done       <= 1'b0;
            frame_data <= '0;
            frame_perr <= 1'b0;
            frame_ferr <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    bit_cnt <= '0;
                    // After a completed frame the line must return high before a new start is accepted.
                    if (!armed) begin
                        armed <= rx_s;
                    end else if (!rx_s) begin
                        state     <= S_START;
                        perr_pend <= 1'b0;
                        ferr_pend <= 1'b0;
                    end
                end
                S_START: begin
                    if (decide && majority) begin
                        state <= S_IDLE;
                    end else if (bit_end) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (decide) begin
                        shift_reg <= {majority, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= bit_cnt + 4'd1;
                    end
                    if (bit_end && (bit_cnt == DATA_LAST)) begin
                        bit_cnt <= '0;
                        state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (decide && (majority != par_expect)) perr_pend <= 1'b1;
                    if (bit_end) state <= S_STOP;
                end
                S_STOP: begin
                    if (decide) begin
                        if (!majority) ferr_pend <= 1'b1;
                        // Complete at the last stop-bit vote so the next start edge is never missed.
                        if (bit_cnt == STOP_LAST) begin
                            done       <= 1'b1;
                            frame_data <= shift_reg;
                            frame_perr <= perr_pend;
                            frame_ferr <= ferr_pend | ~majority;
                            armed      <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Holding register: a completing frame always wins over a same-cycle consume.
    always_ff @(posedge clk50Mhz or posedge reset) begin
        if (reset) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= done && valid && !ready;
            if (done && (!valid || ready)) begin
                data       <= frame_data;
                parity_err <= frame_perr;
                frame_err  <= frame_ferr;
                valid      <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule
